mine_board_builder: RTL and testbench

//  Downstream of the random bomb-position generator. Consumes a stream of 6-bit bomb positions and builds the 8x8 minesweeper board.

---
 rtl/minesweeper_pkg.sv | 22 ++
 rtl/neighbour_counter.sv | 29 ++
 rtl/mine_board_builder.sv | 119 +++++++++++
 tb/tb_mine_board_builder.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/minesweeper_pkg.sv
// Shared types and board geometry for the minesweeper board builder.
package minesweeper_pkg;
  localparam int ROWS      = 8;
  localparam int COLS      = 8;
  localparam int NCELLS    = ROWS * COLS;
  localparam int MAX_BOMBS = 63;

  typedef struct packed {
    logic       bomb;
    logic [3:0] count;
  } cell_t;

  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, COUNT, DONE} state_t;

  function automatic int idx_to_row(input logic [5:0] idx);
    return int'(idx) / COLS;
  endfunction

  function automatic int idx_to_col(input logic [5:0] idx);
    return int'(idx) % COLS;
  endfunction
endpackage

// File: rtl/neighbour_counter.sv
// Combinational count of bombs among the up-to-8 neighbours of one cell.
// Rows and columns are clipped at the board edge; there is no wrap-around.
module neighbour_counter
  import minesweeper_pkg::*;
(
  input  logic [NCELLS-1:0] bombs_i,
  input  logic [5:0]        idx_i,
  output logic [3:0]        count_o
);
  int         r, c;
  logic [5:0] ni;

  always_comb begin
    count_o = '0;
    r       = 0;
    c       = 0;
    ni      = '0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        r = idx_to_row(idx_i) + dr;
        c = idx_to_col(idx_i) + dc;
        if ((dr != 0 || dc != 0) && r >= 0 && r < ROWS && c >= 0 && c < COLS) begin
          ni      = 6'(r * COLS + c);
          count_o = count_o + {3'b000, bombs_i[ni]};
        end
      end
    end
  end
endmodule

// File: rtl/mine_board_builder.sv
// Builds an 8x8 minesweeper board from a stream of bomb positions, then fills
// in adjacency counts one cell per cycle. Optional feature: SAFE_CELL_EN.
module mine_board_builder
  import minesweeper_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [5:0] num_bombs,
`ifdef SAFE_CELL_EN
  input  logic [5:0] safe_pos,
`endif
  input  logic       pos_valid,
  input  logic [5:0] pos_data,
  output logic       pos_ready,
  input  logic [5:0] cell_rd_addr,
  output logic [4:0] cell_rd_data,
  output logic       busy,
  output logic       done,
  output logic [5:0] placed_count,
  output logic       dup_err
);
`ifdef SAFE_CELL_EN
  localparam logic [5:0] NB_MAX = 6'd62;
  logic [5:0] safe_q;
`else
  localparam logic [5:0] NB_MAX = 6'(MAX_BOMBS);
`endif

  state_t            state_q, state_d;
  cell_t             cells_q [NCELLS];
  logic [5:0]        nb_q, placed_q, placed_d, idx_q;
  logic              dup_q, drop, xfer;
  logic [NCELLS-1:0] bombs;
  logic [3:0]        nc;

  always_comb begin
    bombs = '0;
    for (int i = 0; i < NCELLS; i++) bombs[i] = cells_q[i].bomb;
  end

  neighbour_counter u_nc (.bombs_i(bombs), .idx_i(idx_q), .count_o(nc));

  // An already-occupied cell (or the reserved safe cell) swallows the transfer.
  always_comb begin
    drop = cells_q[pos_data].bomb;
`ifdef SAFE_CELL_EN
    if (pos_data == safe_q) drop = 1'b1;
`endif
  end

  assign xfer     = pos_valid && pos_ready;
  assign placed_d = placed_q + {5'd0, xfer && !drop};

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = CLEAR;
      CLEAR:   state_d = (nb_q == '0) ? COUNT : LOAD;
      LOAD:    if (placed_d == nb_q) state_d = COUNT;
      COUNT:   if (idx_q == 6'(NCELLS - 1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pos_ready = (state_q == LOAD);
    busy      = (state_q == CLEAR) || (state_q == LOAD) || (state_q == COUNT);
    done      = (state_q == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NCELLS; i++) cells_q[i] <= '0;
      nb_q     <= '0;
      placed_q <= '0;
      idx_q    <= '0;
      dup_q    <= 1'b0;
`ifdef SAFE_CELL_EN
      safe_q   <= '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: if (start) begin
          nb_q   <= (num_bombs > NB_MAX) ? NB_MAX : num_bombs;
`ifdef SAFE_CELL_EN
          safe_q <= safe_pos;
`endif
        end
        CLEAR: begin
          for (int i = 0; i < NCELLS; i++) cells_q[i] <= '0;
          placed_q <= '0;
          dup_q    <= 1'b0;
          idx_q    <= '0;
        end
        LOAD: if (xfer) begin
          if (drop) dup_q <= 1'b1;
          else      cells_q[pos_data].bomb <= 1'b1;
          placed_q <= placed_d;
        end
        COUNT: begin
          cells_q[idx_q].count <= nc;
          idx_q                <= idx_q + 6'd1;
        end
        default: ;
      endcase
    end
  end

  assign cell_rd_data = cells_q[cell_rd_addr];
  assign placed_count = placed_q;
  assign dup_err      = dup_q;
endmodule

// File: tb/tb_mine_board_builder.sv
// Randomized + directed bench for mine_board_builder against a board-level model.
module tb_mine_board_builder;
  logic       clk = 1'b0;
  logic       rst_n, start, pos_valid, pos_ready, busy, done, dup_err;
  logic [5:0] num_bombs, pos_data, cell_rd_addr, placed_count;
  logic [4:0] cell_rd_data;
`ifdef SAFE_CELL_EN
  logic [5:0] safe_pos;
  localparam int CLAMP = 62;
`else
  localparam int CLAMP = 63;
`endif

  int checks = 0, failures = 0;
  int strm[$];
  int exp_cell[64];
  int exp_placed, exp_dup, exp_xfers;

  mine_board_builder dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_bombs(num_bombs),
`ifdef SAFE_CELL_EN
    .safe_pos(safe_pos),
`endif
    .pos_valid(pos_valid), .pos_data(pos_data), .pos_ready(pos_ready),
    .cell_rd_addr(cell_rd_addr), .cell_rd_data(cell_rd_data), .busy(busy),
    .done(done), .placed_count(placed_count), .dup_err(dup_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Board model: consume the stream until nb unique bombs are placed, then count neighbours.
  task automatic model(input int nb, input int safe);
    int nbe, n, r, c;
    int bomb[64];
    bomb = '{default: 0};
    nbe = (nb > CLAMP) ? CLAMP : nb;
    exp_placed = 0; exp_dup = 0; exp_xfers = 0;
    foreach (strm[j]) begin
      logic dropped;
      if (exp_placed >= nbe) break;
      exp_xfers++;
      dropped = (bomb[strm[j]] != 0);
`ifdef SAFE_CELL_EN
      if (strm[j] == safe) dropped = 1'b1;
`endif
      if (dropped) exp_dup = 1;
      else begin bomb[strm[j]] = 1; exp_placed++; end
    end
    for (int i = 0; i < 64; i++) begin
      r = i / 8; c = i % 8; n = 0;
      for (int rr = r - 1; rr <= r + 1; rr++)
        for (int cc = c - 1; cc <= c + 1; cc++)
          if (rr >= 0 && rr < 8 && cc >= 0 && cc < 8 && !(rr == r && cc == c))
            n += bomb[rr * 8 + cc];
      exp_cell[i] = bomb[i] * 16 + n;
    end
    if (safe < 0) exp_dup = exp_dup; // safe unused without the feature
  endtask

  task automatic check_board(input string tag);
    for (int i = 0; i < 64; i++) begin
      cell_rd_addr = 6'(i);
      #1;
      chk($sformatf("%s_cell%0d", tag, i), cell_rd_data, exp_cell[i]);
    end
  endtask

  task automatic run_build(input string tag, input int nb, input int safe, input bit poke);
    int e, k, done_e;
    bit fire, rdy_seen;
    model(nb, safe);
    @(negedge clk);
    start = 1'b1; num_bombs = 6'(nb);
`ifdef SAFE_CELL_EN
    safe_pos = 6'(safe);
`endif
    @(posedge clk);
    e = 0; k = 0; done_e = -1; rdy_seen = 0;
    while (e < 300) begin
      @(negedge clk);
      start = poke && (e == exp_xfers + 20);
      if (e == 0) chk({tag, "_busy"}, busy, 1);
      if (done) begin done_e = e; break; end
      if (pos_ready) rdy_seen = 1;
      pos_valid = (k < strm.size());
      pos_data  = pos_valid ? 6'(strm[k]) : 6'd0;
      fire = pos_valid && pos_ready;
      @(posedge clk);
      e++;
      if (fire) k++;
    end
    start = 1'b0; pos_valid = 1'b0;
    chk({tag, "_done_cycle"}, done_e + 1, 1 + exp_xfers + 64 + 1);
    chk({tag, "_xfers"}, k, exp_xfers);
    chk({tag, "_placed"}, placed_count, exp_placed);
    chk({tag, "_dup"}, dup_err, exp_dup);
    chk({tag, "_ready_seen"}, rdy_seen, exp_xfers > 0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_busy_after"}, busy, 0);
    check_board(tag);
  endtask

  initial begin
    int free, t, j;
    rst_n = 1'b0; start = 1'b0; pos_valid = 1'b0; num_bombs = '0;
    pos_data = '0; cell_rd_addr = '0;
`ifdef SAFE_CELL_EN
    safe_pos = '0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_ready", pos_ready, 0);
    chk("rst_placed", placed_count, 0); chk("rst_dup", dup_err, 0);
    exp_cell = '{default: 0};
    check_board("rst");
    rst_n = 1'b1;

    strm = '{27};          run_build("t1", 1, 40, 0);
    strm = '{0, 7, 63};    run_build("t2", 3, 40, 0);
    strm = '{5, 5, 9};     run_build("t3", 2, 40, 0);
    strm = '{1, 2, 3};     run_build("t4_nb0", 0, 40, 0);

    // Every cell but one is a bomb.
    free = $urandom_range(0, 63);
    strm = {};
    for (int i = 0; i < 64; i++) if (i != free) strm.push_back(i);
    for (int i = strm.size() - 1; i > 0; i--) begin
      j = $urandom_range(0, i); t = strm[i]; strm[i] = strm[j]; strm[j] = t;
    end
    run_build("t4_full", 63, free, 0);

    for (int it = 0; it < 5; it++) begin
      strm = {};
      for (int i = 0; i < 150; i++) strm.push_back($urandom_range(0, 63));
      run_build($sformatf("rnd%0d", it), $urandom_range(1, 20), $urandom_range(0, 63), it == 2);
    end

    // Reset in the middle of loading.
    @(negedge clk); start = 1'b1; num_bombs = 6'd10;
    @(posedge clk);
    @(negedge clk); start = 1'b0; pos_valid = 1'b1; pos_data = 6'd1;
    @(posedge clk);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk); pos_data = 6'(i);
      @(posedge clk);
    end
    @(negedge clk);
    chk("t5_placed_pre", placed_count, 4);
    rst_n = 1'b0; pos_valid = 1'b0;
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    chk("t5_busy", busy, 0); chk("t5_ready", pos_ready, 0);
    chk("t5_placed", placed_count, 0); chk("t5_dup", dup_err, 0);
    exp_cell = '{default: 0};
    check_board("t5");
    strm = '{12, 13};      run_build("t5_after", 2, 40, 1);

`ifdef SAFE_CELL_EN
    strm = '{10, 11};      run_build("t6_safe", 1, 10, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
